// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration on collisions.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } mem_arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // One-hot grant vector for a master index.
    function automatic logic [1:0] grant_onehot(input logic master);
        logic [1:0] vec;
        if (master == M1) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way picker. Fixed priority (master 1 wins) by default;
// with MEM_ARB_RR_EN defined, a collision goes to the master that did not win last.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick,
    output logic       any
);

    // Decide which requester wins; with no request the pick is a don't-care and follows last
    always_comb begin
        any  = |req;
        pick = last;
        case (req)
            2'b01: pick = M0;
            2'b10: pick = M1;
`ifdef MEM_ARB_RR_EN
            2'b11: pick = ~last;
`else
            2'b11: pick = M1;
`endif
            default: pick = last;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for one PicoRV32-native memory port (master 0 = CPU, master 1 = loader).
// Build macro MEM_ARB_RR_EN: round-robin on simultaneous requests; otherwise master 1 has priority.
// The owner's request is passed combinationally to the memory; ownership changes only in IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_valid,
    input  logic                  m0_instr,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic                  m0_ready,
    output logic [DATA_W-1:0]     m0_rdata,
    input  logic                  m1_valid,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic                  m1_ready,
    output logic [DATA_W-1:0]     m1_rdata,
    input  logic                  m1_lock,
    output logic                  s_valid,
    output logic                  s_instr,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_ready,
    input  logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            grant
);

    localparam int STRB_W = DATA_W / 8;

    mem_arb_state_t state_r;
    mem_arb_state_t state_next_s;
    logic [1:0]     grant_r;
    logic [1:0]     grant_next_s;
    logic           pick_s;
    logic           any_s;
    logic           last_s;

    mem_arb_pick u_pick (
        .req  ({m1_valid, m0_valid}),
        .last (last_s),
        .pick (pick_s),
        .any  (any_s)
    );

`ifdef MEM_ARB_RR_EN
    logic last_r;

    // Remember the winner of each IDLE arbitration so the other master wins the next collision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r <= M1;
        end else if ((state_r == IDLE) && any_s) begin
            last_r <= pick_s;
        end else begin
            last_r <= last_r;
        end
    end

    assign last_s = last_r;
`else
    assign last_s = M1;
`endif

    // Arbitration state and grant registers; reset drops any transfer in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            grant_r <= 2'b00;
        end else begin
            state_r <= state_next_s;
            grant_r <= grant_next_s;
        end
    end

    // Next-state: arbitrate in IDLE, release on completion/abort, hold OWN1 while locked
    always_comb begin
        state_next_s = state_r;
        grant_next_s = grant_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_next_s = (pick_s == M1) ? OWN1 : OWN0;
                    grant_next_s = grant_onehot(pick_s);
                end else begin
                    state_next_s = IDLE;
                    grant_next_s = 2'b00;
                end
            end
            OWN0: begin
                // Completion, or the CPU withdrawing its request, both end ownership
                if (!m0_valid || s_ready) begin
                    state_next_s = IDLE;
                    grant_next_s = 2'b00;
                end else begin
                    state_next_s = OWN0;
                end
            end
            OWN1: begin
                if (m1_valid) begin
                    if (s_ready && !m1_lock) begin
                        state_next_s = IDLE;
                        grant_next_s = 2'b00;
                    end else begin
                        state_next_s = OWN1;
                    end
                end else if (!m1_lock) begin
                    state_next_s = IDLE;
                    grant_next_s = 2'b00;
                end else begin
                    state_next_s = OWN1;
                end
            end
            default: begin
                state_next_s = IDLE;
                grant_next_s = 2'b00;
            end
        endcase
    end

    // Route the owner to the memory port and the memory response back to the owner only
    always_comb begin
        s_valid  = 1'b0;
        s_instr  = 1'b0;
        s_addr   = {ADDR_W{1'b0}};
        s_wdata  = {DATA_W{1'b0}};
        s_wstrb  = {STRB_W{1'b0}};
        m0_ready = 1'b0;
        m0_rdata = {DATA_W{1'b0}};
        m1_ready = 1'b0;
        m1_rdata = {DATA_W{1'b0}};
        case (state_r)
            OWN0: begin
                s_valid  = m0_valid;
                s_instr  = m0_instr;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = s_ready;
                m0_rdata = s_rdata;
            end
            OWN1: begin
                s_valid  = m1_valid;
                s_instr  = 1'b0;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = s_ready;
                m1_rdata = s_rdata;
            end
            default: begin
                s_valid = 1'b0;
            end
        endcase
    end

    assign grant = grant_r;

endmodule
